// File: rtl/sparse_block_encoder.sv
// Dense-to-sparse block compressor: collects BLOCK_SIZE values into an MSB-first
// occupancy mask plus packed nonzeros, then emits a header word followed by the payload.
module sparse_block_encoder #(
  parameter int BLOCK_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  ivalid,
  output logic                  oready,
  input  logic [DATA_WIDTH-1:0] idata,
  output logic                  ovalid,
  input  logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  otype,
  output logic [CNT_WIDTH-1:0]  ocount,
  output logic                  olast
);

  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        in_cnt_r;
  logic [IDX_W-1:0]        rd_ptr_r;
  logic [CNT_WIDTH-1:0]    nz_cnt_r;
  logic [BLOCK_SIZE-1:0]   mask_r;
  logic [DATA_WIDTH-1:0]   buf_r [BLOCK_SIZE];

  logic                    in_xfer_s;
  logic                    out_xfer_s;
  logic                    nonzero_s;
  logic [IDX_W-1:0]        bit_sel_s;
  logic [BLOCK_SIZE-1:0]   mask_next_s;
  logic [CNT_WIDTH-1:0]    nz_next_s;
  logic [IDX_W-1:0]        rd_next_s;
  logic                    last_next_s;
  logic                    first_last_s;

  // Handshakes and the next-value terms for mask, counters and read pointer.
  always_comb begin
    in_xfer_s    = ivalid && oready;
    out_xfer_s   = ovalid && iready;
    nonzero_s    = (idata != '0);
    bit_sel_s    = IDX_MAX - in_cnt_r;
    mask_next_s  = mask_r;
    if (nonzero_s) begin
      mask_next_s[bit_sel_s] = 1'b1;
    end else begin
      mask_next_s = mask_r;
    end
    nz_next_s    = nz_cnt_r + CNT_WIDTH'(nonzero_s);
    rd_next_s    = rd_ptr_r + IDX_W'(1);
    last_next_s  = (CNT_WIDTH'(rd_next_s) == (nz_cnt_r - CNT_WIDTH'(1)));
    first_last_s = (nz_cnt_r == CNT_WIDTH'(1));
  end

  // Collect / header / payload sequencer; all outputs are registered here.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r  <= COLLECT;
      in_cnt_r <= '0;
      rd_ptr_r <= '0;
      nz_cnt_r <= '0;
      mask_r   <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        buf_r[i] <= '0;
      end
      oready   <= 1'b0;
      ovalid   <= 1'b0;
      odata    <= '0;
      otype    <= 1'b0;
      ocount   <= '0;
      olast    <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          oready <= 1'b1;
          if (in_xfer_s) begin
            in_cnt_r <= in_cnt_r + IDX_W'(1);
            mask_r   <= mask_next_s;
            nz_cnt_r <= nz_next_s;
            if (nonzero_s) begin
              buf_r[nz_cnt_r[IDX_W-1:0]] <= idata;
            end
            // Final value of the block: the header already carries its mask bit.
            if (in_cnt_r == IDX_MAX) begin
              state_r <= HEADER;
              oready  <= 1'b0;
              ovalid  <= 1'b1;
              odata   <= DATA_WIDTH'(mask_next_s);
              otype   <= 1'b0;
              ocount  <= nz_next_s;
              olast   <= (nz_next_s == '0);
            end
          end
        end
        HEADER: begin
          if (out_xfer_s) begin
            if (nz_cnt_r == '0) begin
              state_r <= COLLECT;
              mask_r  <= '0;
              oready  <= 1'b1;
              ovalid  <= 1'b0;
              odata   <= '0;
              otype   <= 1'b0;
              ocount  <= '0;
              olast   <= 1'b0;
            end else begin
              state_r  <= PAYLOAD;
              rd_ptr_r <= '0;
              odata    <= buf_r[0];
              otype    <= 1'b1;
              olast    <= first_last_s;
            end
          end
        end
        PAYLOAD: begin
          if (out_xfer_s) begin
            if (olast) begin
              state_r  <= COLLECT;
              nz_cnt_r <= '0;
              mask_r   <= '0;
              rd_ptr_r <= '0;
              oready   <= 1'b1;
              ovalid   <= 1'b0;
              odata    <= '0;
              otype    <= 1'b0;
              ocount   <= '0;
              olast    <= 1'b0;
            end else begin
              rd_ptr_r <= rd_next_s;
              odata    <= buf_r[rd_next_s];
              olast    <= last_next_s;
            end
          end
        end
        default: begin
          state_r  <= COLLECT;
          in_cnt_r <= '0;
          nz_cnt_r <= '0;
          mask_r   <= '0;
          oready   <= 1'b1;
          ovalid   <= 1'b0;
          odata    <= '0;
          otype    <= 1'b0;
          ocount   <= '0;
          olast    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sparse_block_encoder.md
Name: sparse_block_encoder

Overview:
- Write-side counterpart of the operand matcher: compresses a dense stream into the bitmask-plus-packed-nonzero format that the matcher consumes.
- Accepts BLOCK_SIZE dense values, one per transfer, and builds the occupancy bitmask MSB-first. Bit BLOCK_SIZE-1 corresponds to the first value.
- After the block is collected it emits a header word (bitmask and count), then the nonzero values in arrival order.
- Sits between the activation/weight producer and the compressed-buffer writer.

Parameters:
- BLOCK_SIZE, 8: dense values per block. Must be a power of two and >= 2.
- DATA_WIDTH, 8: bits per value. Must be >= BLOCK_SIZE so the bitmask fits in odata.
- CNT_WIDTH, 4: width of ocount. Equals clog2(BLOCK_SIZE+1).

Ports:
- clock, input, 1: single clock, rising edge.
- resetn, input, 1: reset. One clock; reset is asynchronous and active-low.
- ivalid, input, 1: idata valid.
- oready, output, 1: block can accept idata.
- idata, input, DATA_WIDTH: dense input value.
- ovalid, output, 1: output word valid.
- iready, input, 1: downstream accepts the output word.
- odata, output, DATA_WIDTH: header (bitmask, zero-extended) or payload value.
- otype, output, 1: 0 = header, 1 = payload.
- ocount, output, CNT_WIDTH: number of nonzero values in the block. Valid on header, held through payload.
- olast, output, 1: final word of the block.

Behaviour:
- Input handshake: a transfer occurs when ivalid && oready. Output handshake: a transfer occurs when ovalid && iready.
- Asynchronous reset (resetn=0):
  - State = COLLECT; all counters, mask and buffer cleared.
  - Outputs: ovalid=0, odata=0, otype=0, ocount=0, olast=0.
  - oready=0 while resetn=0, and 1 in the first cycle after release.
- Reset asserted mid-block or mid-emission:
  - The partial block is discarded.
  - The output stream is abandoned with no olast.
- States:
  - COLLECT: oready=1, ovalid=0.
    - On each input transfer at index k (in_cnt), mask bit BLOCK_SIZE-1-k is set iff idata != 0 (zero means all bits zero).
    - A nonzero value is written to buf[nz_cnt], then nz_cnt is incremented.
    - On the transfer with k = BLOCK_SIZE-1, go to HEADER; in_cnt wraps to 0.
  - HEADER: oready=0, ovalid=1.
    - Outputs: odata = zero-extended final mask (including the last value's bit), otype=0, ocount=nz_cnt.
    - olast = (nz_cnt==0).
    - On output transfer: if nz_cnt==0, go to COLLECT; else go to PAYLOAD with rd_ptr=0.
  - PAYLOAD: oready=0, ovalid=1.
    - Outputs: odata=buf[rd_ptr], otype=1, ocount held, olast=(rd_ptr==nz_cnt-1).
    - On output transfer: if olast, go to COLLECT and clear nz_cnt and mask; else rd_ptr++.
- Latency:
  - ovalid for the header rises in the cycle after the last input transfer.
  - Payload words follow back-to-back while iready=1.
  - oready returns to 1 in the cycle after the olast transfer.
  - Total = BLOCK_SIZE input cycles + 1 + nz_cnt output cycles, minimum.
- Backpressure: while ovalid && !iready, odata, otype, ocount and olast are held stable. ovalid never drops without a transfer.
- Input side: ivalid may toggle freely in COLLECT; idle cycles do not advance in_cnt. ivalid is ignored while oready=0.
- Width rules:
  - nz_cnt counts 0..BLOCK_SIZE and saturates by construction (CNT_WIDTH bits).
  - in_cnt and rd_ptr are log2(BLOCK_SIZE) bits.
  - mask is zero-extended to DATA_WIDTH in odata.
- No input/output overlap: single buffer, so collection of the next block is blocked during emission.

Test Plan:
- Sparse block: idata 5,0,0,7,0,0,0,9 with iready=1 -> header odata=0x91, ocount=3, olast=0; then payload 5, 7, 9 with olast only on 9; oready=1 on the next cycle.
- All zero: 8 zero inputs -> single header odata=0x00, ocount=0, otype=0, olast=1; return to COLLECT with no payload.
- All dense: 1..8 -> header 0xFF, ocount=8; payload 1..8 in order; olast on 8; in_cnt wraps and the next block's first value maps to mask bit 7.
- Backpressure and gaps:
  - ivalid gaps: input 0,3 on cycles with ivalid low in between, rest zero -> header 0x40, ocount=1.
  - iready low 3 cycles during header and payload: odata/otype/olast are held stable and no words are lost or duplicated.
- Async reset mid-PAYLOAD, after the 1st of 3 payload words: ovalid drops immediately, all outputs are 0, oready=1 after release; the next block 0,0,0,0,0,0,0,4 -> header 0x01, ocount=1, payload 4 with olast=1.
